// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline stage: registered ready, FIFO ordering,
// synchronous flush, and a saturating downstream stall counter.
module pipe_stage #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  flush_i,
    output logic [15:0]           stall_cnt_o,
    output logic [1:0]            state_dbg
);

    // Handshake: a transfer happens on a posedge where valid and ready are both
    // high; valid never waits on ready, and ready_o comes from registered state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [15:0]           stall_q, stall_d;
    logic                  push, pop;

    assign ready_o     = (state_q != TWO);
    assign valid_o     = (state_q != EMPTY);
    assign dat_o       = main_q;
    assign stall_cnt_o = stall_q;
    assign state_dbg   = state_q;

    always_comb begin
        push    = valid_i & ready_o & ~flush_i;
        pop     = valid_o & ready_i;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        // Flush still lets the stall counter observe this cycle.
        if (valid_o && !ready_i && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;

        if (flush_i) begin
            state_d = EMPTY;
            main_d  = FLUSH_VALUE;
            skid_d  = FLUSH_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = dat_i;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                        skid_d  = dat_i;
                    end else if (push && pop) begin
                        main_d  = dat_i;
                    end else if (pop) begin
                        // main keeps the popped value so dat_o stays defined
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_VALUE;
            skid_q  <= FLUSH_VALUE;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of a 2-deep FIFO.
module tb_pipe_stage;

    localparam int          DW    = 32;
    localparam logic [31:0] FLUSH = 32'h0F0F_1234;

    logic          clk;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] dat_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] dat_o;
    logic          flush_i;
    logic [15:0]   stall_cnt_o;
    logic [1:0]    state_dbg;

    pipe_stage #(.DATA_WIDTH(DW), .FLUSH_VALUE(FLUSH)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .dat_i      (dat_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .dat_o      (dat_o),
        .flush_i    (flush_i),
        .stall_cnt_o(stall_cnt_o),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: entries accepted but not yet delivered, oldest first
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_held;
    logic [15:0]   m_stall;
    int            n_checks;
    int            n_fails;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of stimulus; model advances by FIFO rules, then outputs are checked.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic rs);
        logic push, pop;
        valid_i = v;
        dat_i   = d;
        ready_i = r;
        flush_i = f;
        rst     = rs;
        push = v && (exp_q.size() < 2) && !f && !rs;
        pop  = (exp_q.size() > 0) && r && !rs;
        if (pop) check("pop_dat", {32'd0, dat_o}, {32'd0, exp_q[0]});
        if (!rs && exp_q.size() > 0 && !r && m_stall != 16'hFFFF) m_stall++;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
            m_held  = FLUSH;
            m_stall = 16'd0;
        end else if (f) begin
            exp_q.delete();
            m_held = FLUSH;
        end else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(d);
        end
        if (exp_q.size() > 0) m_held = exp_q[0];
        check("valid_o", {63'd0, valid_o}, {63'd0, exp_q.size() > 0});
        check("ready_o", {63'd0, ready_o}, {63'd0, exp_q.size() < 2});
        check("dat_o", {32'd0, dat_o}, {32'd0, m_held});
        check("stall_cnt", {48'd0, stall_cnt_o}, {48'd0, m_stall});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        m_held   = FLUSH;
        m_stall  = 16'd0;
        rst      = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        flush_i  = 1'b0;
        dat_i    = '0;

        // reset state
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // single transfer, one-cycle latency
        step(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0);
        check("lat_dat", {32'd0, dat_o}, 64'hA5A5_A5A5);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // fill to two entries, then drain in order
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        check("two_ready", {63'd0, ready_o}, 64'd0);
        check("two_dat", {32'd0, dat_o}, 64'h11);
        step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);   // offered while full: refused
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drain1", {32'd0, dat_o}, 64'h22);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("drain_empty", {63'd0, valid_o}, 64'd0);
        check("drain_hold", {32'd0, dat_o}, 64'h22);

        // flush while full, incoming entry discarded
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b1, 1'b0);
        check("flush_dat", {32'd0, dat_o}, {32'd0, FLUSH});
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // reset while full with downstream ready
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h88, 1'b1, 1'b0, 1'b1);
        check("rst_stall", {48'd0, stall_cnt_o}, 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // random traffic without flush
        for (int i = 0; i < 10000; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
        // random traffic with occasional flush
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // long stall saturates the counter, reset clears it
        step(1'b1, 32'hC0DE_0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("stall_sat", {48'd0, stall_cnt_o}, 64'hFFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("stall_after_flush", {48'd0, stall_cnt_o}, 64'hFFFF);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("stall_rst", {48'd0, stall_cnt_o}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
